// File: rtl/offchip_mem_model.sv
// Behavioural off-chip memory model: a byte-addressed window of MEMSIZE bytes
// starting at BASE_ADDR, answering single read/write requests after a fixed
// latency with a one-cycle M_DataRdy pulse. Misuse of the bus (oe and we
// together, or an access straddling the end of the window) is recorded in
// sticky error flags that only reset clears.
module offchip_mem_model #(
  parameter int BITSIZE_DATA = 32,
  parameter int BITSIZE_ADDR = 9,
  parameter int MEMSIZE      = 64,
  parameter int BASE_ADDR    = 0,
  parameter int READ_DELAY   = 2,
  parameter int WRITE_DELAY  = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            Mout_oe_ram,
  input  logic                            Mout_we_ram,
  input  logic [BITSIZE_ADDR-1:0]         Mout_addr_ram,
  input  logic [BITSIZE_DATA-1:0]         Mout_Wdata_ram,
  input  logic [$clog2(BITSIZE_DATA):0]   Mout_data_ram_size,
  output logic [BITSIZE_DATA-1:0]         M_Rdata_ram,
  output logic                            M_DataRdy,
  output logic                            err_both,
  output logic                            err_range
);

  localparam int DATA_BYTES = BITSIZE_DATA / 8;
  localparam int MAX_DELAY  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W      = $clog2(MAX_DELAY) + 1;
  localparam int IDX_W      = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  // One extra address bit so addr + bytes can never wrap around.
  localparam int AW         = BITSIZE_ADDR + 1;

  localparam logic [AW-1:0]    WIN_LO  = AW'(BASE_ADDR);
  localparam logic [AW-1:0]    WIN_HI  = AW'(BASE_ADDR + MEMSIZE);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Storage is deliberately outside the reset domain: contents survive reset.
  logic [7:0] mem [MEMSIZE];

  logic [AW-1:0]           addr_ext;
  logic [AW-1:0]           req_bytes;
  logic [AW-1:0]           req_end;
  logic [AW:0]             diff;
  logic [AW-1:0]           offset;
  logic                    below_base;
  logic                    first_in;
  logic                    in_window;
  logic                    req_one;
  logic                    req_both;
  logic                    accept_rd;
  logic                    accept_wr;
  logic [IDX_W-1:0]        lane_idx [DATA_BYTES];
  logic [DATA_BYTES-1:0]   lane_en;
  logic [BITSIZE_DATA-1:0] rd_word;

  // Window decode. The subtraction borrow tells us the address is below the
  // window, which avoids comparing against a base that may be zero.
  assign addr_ext   = {1'b0, Mout_addr_ram};
  assign req_bytes  = AW'(Mout_data_ram_size) >> 3;
  assign req_end    = addr_ext + req_bytes;
  assign diff       = {1'b0, addr_ext} - {1'b0, WIN_LO};
  assign below_base = diff[AW];
  assign offset     = diff[AW-1:0];
  assign first_in   = !below_base && (addr_ext < WIN_HI);
  assign in_window  = !below_base && (req_end <= WIN_HI);
  assign req_one    = Mout_oe_ram ^ Mout_we_ram;
  assign req_both   = Mout_oe_ram & Mout_we_ram;

  // Per-byte-lane memory index and enable, plus the zero-extended read word.
  always_comb begin
    lane_idx = '{default: '0};
    lane_en  = '0;
    rd_word  = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      lane_idx[i] = IDX_W'(offset + AW'(i));
      lane_en[i]  = (AW'(i) < req_bytes);
      if (lane_en[i]) begin
        rd_word[8*i +: 8] = mem[lane_idx[i]];
      end
    end
  end

  // Next-state logic: accept in IDLE, count down latency, pulse RESP once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reset && req_one && in_window) begin
          if (Mout_oe_ram) begin
            accept_rd = 1'b1;
            cnt_d     = RD_LOAD;
            state_d   = (READ_DELAY == 1) ? RESP : RD_WAIT;
          end else begin
            accept_wr = 1'b1;
            cnt_d     = WR_LOAD;
            state_d   = (WRITE_DELAY == 1) ? RESP : WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!Mout_oe_ram) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = RESP;
          end
        end
      end
      WR_WAIT: begin
        if (!Mout_we_ram) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read data capture and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      M_Rdata_ram <= '0;
      err_both    <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (accept_rd) begin
        M_Rdata_ram <= rd_word;
      end
      if (req_both) begin
        err_both <= 1'b1;
      end
      if (state_q == IDLE && req_one && first_in && !in_window) begin
        err_range <= 1'b1;
      end
    end
  end

  // Byte-lane write commit on the accepting edge.
  always_ff @(posedge clock) begin
    if (accept_wr) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (lane_en[i]) begin
          mem[lane_idx[i]] <= Mout_Wdata_ram[8*i +: 8];
        end
      end
    end
  end

  assign M_DataRdy = (state_q == RESP);

endmodule

// File: tb/tb_offchip_mem_model.sv
// Scoreboard bench for offchip_mem_model: two instances (default latencies and
// a 4-cycle read latency), a byte-array reference memory, an expectation queue
// filled by the driver and drained by an independent monitor.
module tb_offchip_mem_model;

  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int SW  = 6;
  localparam int WIN = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          oe    [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [SW-1:0] size  [2];
  logic [DW-1:0] rdata [2];
  logic          rdy   [2];
  logic          eb    [2];
  logic          er    [2];

  typedef struct {
    int          dut;
    bit          is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] mem_m [2][WIN];
  bit         exp_eb [2];
  bit         exp_er [2];
  int         lat_rd [2] = '{2, 4};
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  offchip_mem_model dut0 (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (oe[0]),
    .Mout_we_ram        (we[0]),
    .Mout_addr_ram      (addr[0]),
    .Mout_Wdata_ram     (wdata[0]),
    .Mout_data_ram_size (size[0]),
    .M_Rdata_ram        (rdata[0]),
    .M_DataRdy          (rdy[0]),
    .err_both           (eb[0]),
    .err_range          (er[0])
  );

  offchip_mem_model #(.READ_DELAY(4)) dut1 (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (oe[1]),
    .Mout_we_ram        (we[1]),
    .Mout_addr_ram      (addr[1]),
    .Mout_Wdata_ram     (wdata[1]),
    .Mout_data_ram_size (size[1]),
    .M_Rdata_ram        (rdata[1]),
    .M_DataRdy          (rdy[1]),
    .err_both           (eb[1]),
    .err_range          (er[1])
  );

  always #5 clock = ~clock;

  // Rising-edge counter used to timestamp expected completions.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drive one request (called at a falling edge) and hold it for 'hold' edges.
  task automatic apply_stimulus(input int d, input bit o, input bit w, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [SW-1:0] sz, input int hold);
    oe[d]    = o;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    size[d]  = sz;
    repeat (hold) @(negedge clock);
    oe[d] = 1'b0;
    we[d] = 1'b0;
  endtask

  // Reference model: a request is served iff it fits wholly in [0, WIN);
  // completion is seen in the cycle 'delay' edges after issue.
  task automatic do_access(input int d, input bit is_wr, input int a, input logic [31:0] wd, input int sz_bits);
    int   nb;
    int   delay;
    exp_t e;
    nb = sz_bits / 8;
    if (a + nb <= WIN) begin
      delay   = is_wr ? 1 : lat_rd[d];
      e.dut   = d;
      e.is_rd = !is_wr;
      e.data  = '0;
      e.cyc   = cyc + delay;
      for (int i = 0; i < nb; i++) begin
        if (is_wr) mem_m[d][a+i] = wd[8*i +: 8];
        else       e.data[8*i +: 8] = mem_m[d][a+i];
      end
      exp_q.push_back(e);
      apply_stimulus(d, !is_wr, is_wr, a[AW-1:0], wd, sz_bits[SW-1:0], delay + 1);
    end else begin
      if (a < WIN) exp_er[d] = 1'b1;
      apply_stimulus(d, !is_wr, is_wr, a[AW-1:0], wd, sz_bits[SW-1:0], 2);
    end
    @(negedge clock);
    check_output("err_range", {31'd0, er[d]}, {31'd0, exp_er[d]});
    check_output("err_both", {31'd0, eb[d]}, {31'd0, exp_eb[d]});
  endtask

  // Monitor: every M_DataRdy pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rdy[d]) begin
        if (exp_q.size() != 0 && exp_q[0].dut == d) begin
          e = exp_q.pop_front();
          check_output("rdy_cycle", cyc, e.cyc);
          if (e.is_rd) check_output("rdata", rdata[d], e.data);
        end else begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_rdy dut%0d: got M_DataRdy=1 at cycle %0d, expected 0", d, cyc);
        end
      end
    end
    if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_rdy dut%0d: got no M_DataRdy by cycle %0d, expected at cycle %0d",
               exp_q[0].dut, cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      oe[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; size[d] = '0;
      exp_eb[d] = 1'b0; exp_er[d] = 1'b0;
    end

    // Reset state.
    #1 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output("reset_rdata", rdata[d], 32'd0);
      check_output("reset_rdy", {31'd0, rdy[d]}, 32'd0);
      check_output("reset_err_both", {31'd0, eb[d]}, 32'd0);
      check_output("reset_err_range", {31'd0, er[d]}, 32'd0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Give every byte of both windows a known value.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < WIN / 4; w++)
        do_access(d, 1'b1, 4 * w, $urandom, 32);

    // Directed cases on the default instance.
    do_access(0, 1'b1, 'h10, 32'hDEADBEEF, 32);
    do_access(0, 1'b0, 'h10, '0, 32);
    do_access(0, 1'b1, 'h11, 32'h000000AA, 8);
    do_access(0, 1'b0, 'h10, '0, 32);
    do_access(0, 1'b0, 'h3E, '0, 32);
    do_access(0, 1'b0, 'h3E, '0, 16);

    // oe and we together for one cycle: flagged, nothing written.
    apply_stimulus(0, 1'b1, 1'b1, 'h10, 32'h12345678, 6'd32, 1);
    exp_eb[0] = 1'b1;
    @(negedge clock);
    check_output("conflict_err_both", {31'd0, eb[0]}, 32'd1);
    do_access(0, 1'b0, 'h10, '0, 32);

    // Randomized traffic, occasionally outside or straddling the window.
    for (int k = 0; k < 40; k++) begin
      int nb;
      int a;
      bit w;
      nb = 1 << $urandom_range(0, 2);
      w  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) a = int'($urandom_range(60, 300));
      else                           a = int'($urandom_range(0, WIN - nb));
      do_access(0, w, a, $urandom, nb * 8);
    end

    // Reset while a read is waiting: outputs clear at once, memory survives.
    oe[0] = 1'b1; we[0] = 1'b0; addr[0] = 'h10; size[0] = 6'd32;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_output("midreset_rdy", {31'd0, rdy[0]}, 32'd0);
    check_output("midreset_rdata", rdata[0], 32'd0);
    check_output("midreset_err_both", {31'd0, eb[0]}, 32'd0);
    check_output("midreset_err_range", {31'd0, er[0]}, 32'd0);
    exp_eb[0] = 1'b0;
    exp_er[0] = 1'b0;
    oe[0] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    do_access(0, 1'b0, 'h10, '0, 32);
    do_access(0, 1'b0, 'h20, '0, 16);

    // Slow-read instance: abort after two cycles, then a complete read.
    do_access(1, 1'b1, 'h08, 32'hCAFE0123, 32);
    apply_stimulus(1, 1'b1, 1'b0, 'h08, '0, 6'd32, 2);
    repeat (4) @(negedge clock);
    do_access(1, 1'b0, 'h08, '0, 32);
    do_access(1, 1'b0, 'h09, '0, 8);

    repeat (6) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
